// File: rtl/alsu_gen2.sv
// Registered ALSU: one request at a time, multi-cycle signed shift-add multiply, sticky error LEDs.
// Optional build macro ALSU_SAT_ADD_EN clamps ADD results to the signed WIDTH-bit range.
module alsu_gen2 #(
   parameter int WIDTH          = 3,
   parameter     FULL_ADDER     = "ON",
   parameter     INPUT_PRIORITY = "A"
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 cin,
   input  logic                 serial_in,
   input  logic                 direction,
   input  logic                 red_op_A,
   input  logic                 red_op_B,
   input  logic                 bypass_A,
   input  logic                 bypass_B,
   input  logic [2:0]           opcode,
   output logic [2*WIDTH-1:0]   out,
   output logic                 out_valid,
   output logic [15:0]          leds
);
   localparam int OW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);
   localparam logic [2:0] OP_OR = 3'd0, OP_XOR = 3'd1, OP_ADD = 3'd2, OP_MULT = 3'd3,
                          OP_SHIFT = 3'd4, OP_ROTATE = 3'd5;
   localparam bit   PRIO_A = (INPUT_PRIORITY == "A");
   localparam logic CIN_EN = (FULL_ADDER == "ON");

   typedef enum logic [1:0] {IDLE, EXEC, MULT, ERR} state_t;
   state_t state_reg, state_next;

   logic [WIDTH-1:0] a_reg, b_reg, mplier_reg;
   logic [2:0]       opcode_reg;
   logic             cin_reg, serial_in_reg, direction_reg;
   logic             red_a_reg, red_b_reg, bypass_a_reg, bypass_b_reg;
   logic [OW-1:0]    acc_reg, mcand_reg, out_reg;
   logic [CW-1:0]    cnt_reg;
   logic             out_valid_reg, err_reg;
   logic [15:0]      leds_reg;

   logic             accept, req_invalid, bypass_hit, mult_last;
   logic [OW-1:0]    a_ext, b_ext, bypass_val, add_val, exec_val, mult_term, acc_next;
   logic [WIDTH:0]   sum;
`ifdef ALSU_SAT_ADD_EN
   logic [WIDTH-1:0] sat_val;
`endif

   assign in_ready  = (state_reg == IDLE);
   assign accept    = in_valid & in_ready;
   assign out       = out_reg;
   assign out_valid = out_valid_reg;
   assign leds      = leds_reg;

   // Reduction flags are only meaningful for the bitwise opcodes.
   assign req_invalid = (opcode > OP_ROTATE) ||
                        ((red_op_A | red_op_B) && (opcode != OP_OR) && (opcode != OP_XOR));

   assign a_ext      = {{WIDTH{a_reg[WIDTH-1]}}, a_reg};
   assign b_ext      = {{WIDTH{b_reg[WIDTH-1]}}, b_reg};
   assign bypass_hit = bypass_a_reg | bypass_b_reg;
   assign bypass_val = (bypass_a_reg && (PRIO_A || !bypass_b_reg)) ? a_ext : b_ext;

   assign sum = {a_reg[WIDTH-1], a_reg} + {b_reg[WIDTH-1], b_reg} +
                {{WIDTH{1'b0}}, cin_reg & CIN_EN};

`ifdef ALSU_SAT_ADD_EN
   always_comb begin
      sat_val = sum[WIDTH-1:0];
      if (sum[WIDTH] != sum[WIDTH-1])
         sat_val = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   end
   assign add_val = {{WIDTH{sat_val[WIDTH-1]}}, sat_val};
`else
   assign add_val = {{(WIDTH-1){sum[WIDTH]}}, sum};
`endif

   always_comb begin
      exec_val = '0;
      case (opcode_reg)
         OP_OR: begin
            if (red_a_reg)      exec_val = {{(OW-1){1'b0}}, |a_reg};
            else if (red_b_reg) exec_val = {{(OW-1){1'b0}}, |b_reg};
            else                exec_val = a_ext | b_ext;
         end
         OP_XOR: begin
            if (red_a_reg)      exec_val = {{(OW-1){1'b0}}, ^a_reg};
            else if (red_b_reg) exec_val = {{(OW-1){1'b0}}, ^b_reg};
            else                exec_val = a_ext ^ b_ext;
         end
         OP_ADD:    exec_val = add_val;
         OP_SHIFT:  exec_val = direction_reg ? {out_reg[OW-2:0], serial_in_reg}
                                             : {serial_in_reg, out_reg[OW-1:1]};
         OP_ROTATE: exec_val = direction_reg ? {out_reg[OW-2:0], out_reg[OW-1]}
                                             : {out_reg[0], out_reg[OW-1:1]};
         default:   exec_val = '0;
      endcase
      if (bypass_hit) exec_val = bypass_val;
   end

   // Two's-complement multiplier: the sign bit of B carries negative weight, so the last step subtracts.
   assign mult_last = (cnt_reg == CW'(WIDTH - 1));
   assign mult_term = mplier_reg[0] ? mcand_reg : '0;
   assign acc_next  = mult_last ? (acc_reg - mult_term) : (acc_reg + mult_term);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) begin
            if (req_invalid)             state_next = ERR;
            else if (opcode == OP_MULT)  state_next = MULT;
            else                         state_next = EXEC;
         end
         MULT:    if (mult_last) state_next = IDLE;
         EXEC:    state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         a_reg         <= '0;
         b_reg         <= '0;
         opcode_reg    <= '0;
         cin_reg       <= 1'b0;
         serial_in_reg <= 1'b0;
         direction_reg <= 1'b0;
         red_a_reg     <= 1'b0;
         red_b_reg     <= 1'b0;
         bypass_a_reg  <= 1'b0;
         bypass_b_reg  <= 1'b0;
         acc_reg       <= '0;
         mcand_reg     <= '0;
         mplier_reg    <= '0;
         cnt_reg       <= '0;
         out_reg       <= '0;
         out_valid_reg <= 1'b0;
         err_reg       <= 1'b0;
         leds_reg      <= '0;
      end else begin
         state_reg     <= state_next;
         out_valid_reg <= 1'b0;
         if (accept) begin
            a_reg         <= A;
            b_reg         <= B;
            opcode_reg    <= opcode;
            cin_reg       <= cin;
            serial_in_reg <= serial_in;
            direction_reg <= direction;
            red_a_reg     <= red_op_A;
            red_b_reg     <= red_op_B;
            bypass_a_reg  <= bypass_A;
            bypass_b_reg  <= bypass_B;
            acc_reg       <= '0;
            mcand_reg     <= {{WIDTH{A[WIDTH-1]}}, A};
            mplier_reg    <= B;
            cnt_reg       <= '0;
         end
         case (state_reg)
            EXEC: begin
               out_reg       <= exec_val;
               out_valid_reg <= 1'b1;
            end
            MULT: begin
               acc_reg    <= acc_next;
               mcand_reg  <= mcand_reg << 1;
               mplier_reg <= mplier_reg >> 1;
               cnt_reg    <= cnt_reg + CW'(1);
               if (mult_last) begin
                  out_reg       <= bypass_hit ? bypass_val : acc_next;
                  out_valid_reg <= 1'b1;
               end
            end
            ERR: begin
               out_reg       <= '0;
               out_valid_reg <= 1'b1;
            end
            default: ;
         endcase
         // Error LEDs blink from the error edge until a valid request is taken.
         if (accept && !req_invalid) begin
            err_reg  <= 1'b0;
            leds_reg <= '0;
         end else if (state_reg == ERR) begin
            err_reg  <= 1'b1;
            leds_reg <= '1;
         end else if (err_reg) begin
            leds_reg <= ~leds_reg;
         end else begin
            leds_reg <= '0;
         end
      end
   end
endmodule

// File: tb/tb_alsu_gen2.sv
// Scoreboard bench for alsu_gen2 (WIDTH=3, default parameters): directed corner cases plus random requests.
module tb_alsu_gen2;
   localparam int W  = 3;
   localparam int OW = 2 * W;

   logic          clk = 1'b0;
   logic          reset, in_valid, in_ready;
   logic [W-1:0]  A, B;
   logic          cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
   logic [2:0]    opcode;
   logic [OW-1:0] out;
   logic          out_valid;
   logic [15:0]   leds;

   always #5 clk = ~clk;

   alsu_gen2 #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .cin(cin), .serial_in(serial_in), .direction(direction),
      .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
      .opcode(opcode), .out(out), .out_valid(out_valid), .leds(leds)
   );

   typedef struct {
      logic [OW-1:0] out;
      logic [15:0]   leds;
      int            cyc;
      int            id;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   model_out = 0;
   int   next_id = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   function automatic int sx(input int v);
      int m;
      m = v & ((1 << W) - 1);
      return (m >= (1 << (W - 1))) ? m - (1 << W) : m;
   endfunction

   // Reference model: plain integer arithmetic on the request fields.
   task automatic send(input int op, input int a, input int b, input int ci, input int si,
                       input int dir, input int ra, input int rb, input int ba, input int bb);
      int waited, res, lat, s;
      logic [15:0] lexp;
      exp_t e;
      waited = 0;
      @(negedge clk);
      while (!in_ready) begin
         waited++;
         if (waited > 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", waited);
            return;
         end
         @(negedge clk);
      end
      opcode = 3'(op); A = W'(a); B = W'(b); cin = 1'(ci); serial_in = 1'(si);
      direction = 1'(dir); red_op_A = 1'(ra); red_op_B = 1'(rb);
      bypass_A = 1'(ba); bypass_B = 1'(bb);
      in_valid = 1'b1;
      lat  = (op == 3) ? W : 1;
      lexp = 16'h0000;
      if (op > 5 || ((ra != 0 || rb != 0) && op > 1)) begin
         res = 0; lat = 1; lexp = 16'hFFFF;
      end else if (ba != 0 || bb != 0) begin
         res = (ba != 0) ? sx(a) : sx(b);
      end else begin
         case (op)
            0: res = (ra != 0) ? int'((a & 7) != 0) : (rb != 0) ? int'((b & 7) != 0) : (sx(a) | sx(b));
            1: res = (ra != 0) ? ($countones(a & 7) & 1) : (rb != 0) ? ($countones(b & 7) & 1) : (sx(a) ^ sx(b));
            2: begin
               s = sx(a) + sx(b) + ci;
`ifdef ALSU_SAT_ADD_EN
               if (s > (1 << (W - 1)) - 1) s = (1 << (W - 1)) - 1;
               if (s < -(1 << (W - 1)))    s = -(1 << (W - 1));
`endif
               res = s;
            end
            3: res = sx(a) * sx(b);
            4: res = (dir != 0) ? ((model_out << 1) | si) : ((model_out >> 1) | (si << (OW - 1)));
            default: res = (dir != 0) ? ((model_out << 1) | (model_out >> (OW - 1)))
                                      : ((model_out >> 1) | ((model_out & 1) << (OW - 1)));
         endcase
      end
      model_out = res & ((1 << OW) - 1);
      e.out  = OW'(model_out);
      e.leds = lexp;
      e.cyc  = cyc + 1 + lat;
      e.id   = next_id++;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out_valid: got pulse with out=%0h, expected no pulse", out);
         end else begin
            mon_e = sb.pop_front();
            $display("txn %0d: out=%0h leds=%0h cycle=%0d", mon_e.id, out, leds, cyc);
            check("out", 32'(out), 32'(mon_e.out));
            check("leds_at_result", 32'(leds), 32'(mon_e.leds));
            check("latency", 32'(cyc), 32'(mon_e.cyc));
         end
      end
   end

   initial begin
      int waited;
      reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; cin = 1'b0; serial_in = 1'b0;
      direction = 1'b0; red_op_A = 1'b0; red_op_B = 1'b0; bypass_A = 1'b0; bypass_B = 1'b0;
      opcode = '0;
      repeat (3) @(negedge clk);
      check("reset_out", 32'(out), 0);
      check("reset_out_valid", 32'(out_valid), 0);
      check("reset_leds", 32'(leds), 0);
      check("reset_in_ready", 32'(in_ready), 1);
      reset = 1'b0;

      // ADD with carry-in, one-cycle latency
      send(2, 3, 2, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("add_3_2_1_valid", 32'(out_valid), 1);
      check("add_3_2_1", 32'(out), 32'h06);
      // ADD overflow boundary
      send(2, 3, 3, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
`ifdef ALSU_SAT_ADD_EN
      check("add_3_3_1", 32'(out), 32'h03);
`else
      check("add_3_3_1", 32'(out), 32'h07);
`endif

      // MULT -2*3; requests offered while busy must be ignored
      send(3, 6, 3, 0, 0, 0, 0, 0, 0, 0);
      check("mult_busy_0", 32'(in_ready), 0);
      in_valid = 1'b1; opcode = 3'd2; A = 3'd1; B = 3'd1;
      @(negedge clk);
      check("mult_busy_1", 32'(in_ready), 0);
      @(negedge clk);
      check("mult_busy_2", 32'(in_ready), 0);
      in_valid = 1'b0;
      @(negedge clk);
      check("mult_done_ready", 32'(in_ready), 1);
      check("mult_done_valid", 32'(out_valid), 1);
      check("mult_m2_3", 32'(out), 32'h3A);

      // Invalid opcode: out cleared, LEDs blink until a valid request
      send(6, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("err_out", 32'(out), 0);
      check("err_leds_0", 32'(leds), 32'hFFFF);
      @(negedge clk);
      check("err_leds_1", 32'(leds), 32'h0000);
      @(negedge clk);
      check("err_leds_2", 32'(leds), 32'hFFFF);
      send(2, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      check("err_cleared_leds", 32'(leds), 0);
      @(negedge clk);

      // Build 100001, then rotate and shift
      send(0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) send(4, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      send(4, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      @(negedge clk);
      check("shift_build", 32'(out), 32'h21);
      send(5, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      @(negedge clk);
      check("rotate_left", 32'(out), 32'h03);
      send(5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      send(4, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("shift_right_si1", 32'(out), 32'h30);

      // Reset during cycle 2 of MULT aborts it
      send(3, 3, 3, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      sb.delete();
      model_out = 0;
      @(negedge clk);
      reset = 1'b0;
      check("abort_out", 32'(out), 0);
      check("abort_out_valid", 32'(out_valid), 0);
      check("abort_in_ready", 32'(in_ready), 1);
      repeat (5) @(negedge clk);

      // Random requests
      for (int i = 0; i < 300; i++) begin
         int op, ra, rb, ba, bb;
         op = ($urandom_range(0, 15) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
         ra = ($urandom_range(0, 7) == 0) ? 1 : 0;
         rb = ($urandom_range(0, 7) == 0) ? 1 : 0;
         ba = ($urandom_range(0, 7) == 0) ? 1 : 0;
         bb = ($urandom_range(0, 7) == 0) ? 1 : 0;
         send(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), ra, rb, ba, bb);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      waited = 0;
      while (sb.size() != 0 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d results outstanding, expected 0", sb.size());
      end
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/alsu_gen2.md
ALSU_GEN2 -- requirements
Module: alsu_gen2

Interface
REQ-001 SHALL have parameter WIDTH, default 3, operand width in bits (legal 2..16).
REQ-002 SHALL have parameter FULL_ADDER, default "ON", which adds cin into ADD when "ON".
REQ-003 SHALL have parameter INPUT_PRIORITY, default "A", which selects the winning bypass when both bypass_A and bypass_B are high.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, request present.
REQ-007 SHALL have port in_ready, output, 1, block can accept a request.
REQ-008 SHALL have ports A and B, input, WIDTH each, signed operands.
REQ-009 SHALL have ports cin, serial_in, direction, red_op_A, red_op_B, bypass_A and bypass_B, input, 1 each; direction 1 = left.
REQ-010 SHALL have port opcode, input, 3, encoded OR=0, XOR=1, ADD=2, MULT=3, SHIFT=4, ROTATE=5; 6 and 7 invalid.
REQ-011 SHALL have port out, output, 2*WIDTH, registered result.
REQ-012 SHALL have port out_valid, output, 1, one-cycle pulse per completed request.
REQ-013 SHALL have port leds, output, 16, error indicator.

Function
REQ-014 SHALL capture all request inputs into a register on the accept edge (in_valid & in_ready).
REQ-015 SHALL use FSM states IDLE, EXEC, MULT, ERR; IDLE->EXEC on accept of a non-MULT valid op, IDLE->MULT on accept of MULT, IDLE->ERR on accept of an invalid op, EXEC->IDLE after one cycle, MULT->IDLE after WIDTH cycles, ERR->IDLE after one cycle.
REQ-016 SHALL drive in_ready high only in IDLE.
REQ-017 SHALL flag a request invalid when opcode is 6 or 7, or when red_op_A/red_op_B is set with an opcode other than OR/XOR.
REQ-018 SHALL give bypass precedence over every opcode: out = sign-extended bypassed operand; when both bypasses are set, A wins if INPUT_PRIORITY=="A", else B.
REQ-019 SHALL, for OR/XOR with red_op_A (priority over red_op_B), set out = zero-extended reduction-OR/XOR of A (of B for red_op_B); otherwise out = sign-extended A|B or A^B.
REQ-020 SHALL compute ADD as A+B(+cin), signed, sign-extended to 2*WIDTH.
REQ-021 SHALL compute MULT as a signed shift-add over WIDTH cycles; out holds its previous value until completion, then takes full 2*WIDTH product.
REQ-022 SHALL compute SHIFT as out <= {out[2W-2:0],serial_in} when left, else {serial_in,out[2W-1:1]}.
REQ-023 SHALL compute ROTATE as out <= {out[2W-2:0],out[2W-1]} when left, else {out[0],out[2W-1:1]}.
REQ-024 SHALL give latency: accept at edge k; non-MULT result and out_valid at edge k+1; MULT at edge k+WIDTH.
REQ-025 SHALL, on an invalid op, clear out to 0, pulse out_valid, and set a sticky error flag.
REQ-026 SHALL, while the error flag is set, invert leds every cycle (first value 16'hFFFF); leds = 0 when the flag is clear; the flag clears on the next accepted valid op.
REQ-027 SHALL ignore in_valid while in_ready is low; the request is neither queued nor dropped silently (the source holds).

Reset
REQ-028 SHALL, on reset high at a clock edge, force state IDLE, out=0, out_valid=0, leds=0, error flag=0, in_ready=1 from the next cycle; reset SHALL abort an in-flight MULT with no out_valid.

Configuration
REQ-029 SHALL, with ALSU_SAT_ADD_EN defined, clamp the ADD result to the signed WIDTH-bit range [-2^(W-1), 2^(W-1)-1] before sign extension; without it, the ADD result is the unclamped WIDTH+1-bit sum.

Verification (WIDTH=3, defaults)
REQ-030 SHALL cover: ADD A=3, B=2, cin=1 -> out=6'b000110 with out_valid one cycle after accept (macro off).
REQ-031 SHALL cover: MULT A=3'b110 (-2), B=3 -> in_ready low 3 cycles, then out=6'b111010 with single out_valid pulse.
REQ-032 SHALL cover: opcode=6 -> out=0, leds=16'hFFFF then 16'h0000 alternating until a valid ADD clears them to 0.
REQ-033 SHALL cover: out=6'b100001, ROTATE left -> 6'b000011; SHIFT right with serial_in=1 -> 6'b110000.
REQ-034 SHALL cover: reset asserted during cycle 2 of MULT -> out=0, no out_valid, in_ready=1 the following cycle.
REQ-035 SHALL cover: ALSU_SAT_ADD_EN defined, ADD A=3, B=3, cin=1 -> out=6'b000011; undefined -> 6'b000111.
